// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer: per-key FSM states
// and the millisecond-to-clock-cycle conversion used to size the timers.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    function automatic int msToCycles(input int clkFreq, input int ms);
        return clkFreq / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, debounce FSM and the registered
// press / release / long-press pulses for a single key.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYC    = 8,
    parameter int LONG_CYC   = 40,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DCNT_W = $clog2(DEB_CYC - 1) + 1;
    localparam int LCNT_W = $clog2(LONG_CYC - 1) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYC - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYC - 1);
    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic              sync1_q, sync2_q, keyS;
    key_state_t        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              longDone_q, longDone_d;
    logic              keyState_q, keyState_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Synchroniser resets to the released pin level so leaving reset is silent
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign keyS = sync2_q ^ IDLE_LEVEL;

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        lcnt_d     = lcnt_q;
        longDone_d = longDone_q;
        keyState_d = keyState_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (keyS) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!keyS) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    keyState_d = 1'b1;
                    lcnt_d     = '0;
                    longDone_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            PRESSED: begin
                if (!keyS) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (lcnt_q == LCNT_LAST) begin
                    // Hold timer saturates here; long-press fires only on the first visit
                    if (!longDone_q) begin
                        long_d     = 1'b1;
                        longDone_d = 1'b1;
                    end
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (keyS) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    keyState_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            lcnt_q     <= '0;
            longDone_q <= 1'b0;
            keyState_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            lcnt_q     <= lcnt_d;
            longDone_q <= longDone_d;
            keyState_q <= keyState_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign state_o   = keyState_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: KEY_NUM independent debounce channels producing
// clean key levels and one-cycle press / release / long-press pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int KEY_NUM     = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int DEB_CYC  = msToCycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int LONG_CYC = msToCycles(CLK_FREQ, LONG_MS);

    if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC) begin : gBadParams
        $error("key_debounce: need DEB_CYC >= 2 and LONG_CYC > DEB_CYC");
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : gKey
        key_debounce_ch #(
            .DEB_CYC   (DEB_CYC),
            .LONG_CYC  (LONG_CYC),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) uCh (
            .clk_i    (sys_clk),
            .rst_i    (rst),
            .key_i    (key_in[k]),
            .state_o  (key_state[k]),
            .press_o  (key_press[k]),
            .release_o(key_release[k]),
            .long_o   (key_long[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce at 1 cycle/ms: pin-edge stimulus schedules expected
// pulses by clock edge; a per-cycle monitor compares every output every cycle.
module tb_key_debounce;

    localparam int DEB_CYC  = 8;
    localparam int LONG_CYC = 40;
    localparam int LAT      = DEB_CYC + 2;

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } ev_t;

    typedef struct {
        int key;
        int lowLen;
        bit expPress;
        bit expLong;
    } vec_t;

    logic       sysClk = 1'b0;
    logic       rst;
    logic [3:0] keyIn;
    logic [3:0] keyState, keyPress, keyRelease, keyLong;

    int         edgeNo = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        sb[$];
    logic [3:0] expState = 4'h0;
    logic [3:0] eP, eR, eL;
    vec_t       vecs[8];

    key_debounce #(
        .CLK_FREQ   (1000),
        .KEY_NUM    (4),
        .DEBOUNCE_MS(8),
        .LONG_MS    (40),
        .ACTIVE_LOW (1)
    ) dut (
        .sys_clk    (sysClk),
        .rst        (rst),
        .key_in     (keyIn),
        .key_state  (keyState),
        .key_press  (keyPress),
        .key_release(keyRelease),
        .key_long   (keyLong)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) edgeNo <= edgeNo + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNo, act, exp);
        end
    endtask

    // Outputs sampled mid-cycle; anything not scheduled for this edge must be 0
    always @(negedge sysClk) begin
        eP = 4'h0;
        eR = 4'h0;
        eL = 4'h0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edgeNo) begin
                eP |= sb[i].press;
                eR |= sb[i].rel;
                eL |= sb[i].lng;
                sb.delete(i);
            end
        end
        expState = (expState | eP) & ~eR;
        checkOutput("key_press", 32'(keyPress), 32'(eP));
        checkOutput("key_release", 32'(keyRelease), 32'(eR));
        checkOutput("key_long", 32'(keyLong), 32'(eL));
        checkOutput("key_state", 32'(keyState), 32'(expState));
    end

    task automatic pushEv(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.at    = at;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        sb.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge sysClk);
            n++;
        end
        checkOutput("events_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        waitCycles(12);
    endtask

    task automatic applyReset();
        #1;
        rst      = 1'b1;
        sb.delete();
        expState = 4'h0;
    endtask

    task automatic releaseReset();
        @(negedge sysClk);
        #1 rst = 1'b0;
    endtask

    // Drive one key low for lowLen edges; press/long/release timing follows the pin edge
    task automatic applyStimulus(input vec_t v);
        int         s;
        logic [3:0] m;
        m = 4'b0001 << v.key;
        @(negedge sysClk);
        keyIn[v.key] = 1'b0;
        s = edgeNo + 1;
        if (v.expPress) begin
            pushEv(s + LAT, m, 4'h0, 4'h0);
            pushEv(s + v.lowLen + LAT, 4'h0, m, 4'h0);
        end
        if (v.expLong) pushEv(s + LAT + LONG_CYC, 4'h0, 4'h0, m);
        waitCycles(v.lowLen);
        keyIn[v.key] = 1'b1;
        drain(200);
    endtask

    initial begin
        int s;
        keyIn = 4'hF;
        rst   = 1'b0;
        vecs[0] = '{0, 30, 1'b1, 1'b0};
        vecs[1] = '{2, 60, 1'b1, 1'b1};
        vecs[2] = '{3, 20, 1'b1, 1'b0};
        vecs[3] = '{3,  5, 1'b0, 1'b0};
        vecs[4] = '{1,  8, 1'b0, 1'b0};
        vecs[5] = '{1,  9, 1'b1, 1'b0};
        vecs[6] = '{1, 48, 1'b1, 1'b0};
        vecs[7] = '{1, 49, 1'b1, 1'b1};

        #1 rst = 1'b1;
        waitCycles(4);
        releaseReset();
        waitCycles(6);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        $display("[TB] bounce on key 1");
        @(negedge sysClk);
        for (int r = 0; r < 5; r++) begin
            keyIn[1] = 1'b0;
            waitCycles(3);
            keyIn[1] = 1'b1;
            waitCycles(2);
        end
        keyIn[1] = 1'b0;
        s = edgeNo + 1;
        pushEv(s + LAT, 4'b0010, 4'h0, 4'h0);
        pushEv(s + 20 + LAT, 4'h0, 4'b0010, 4'h0);
        waitCycles(20);
        keyIn[1] = 1'b1;
        drain(100);

        $display("[TB] release glitch on key 0");
        @(negedge sysClk);
        keyIn[0] = 1'b0;
        s = edgeNo + 1;
        pushEv(s + LAT, 4'b0001, 4'h0, 4'h0);
        waitCycles(20);
        keyIn[0] = 1'b1;
        waitCycles(3);
        keyIn[0] = 1'b0;
        waitCycles(10);
        keyIn[0] = 1'b1;
        pushEv(s + 33 + LAT, 4'h0, 4'b0001, 4'h0);
        drain(100);

        $display("[TB] simultaneous press on all keys");
        @(negedge sysClk);
        keyIn = 4'h0;
        s = edgeNo + 1;
        pushEv(s + LAT, 4'hF, 4'h0, 4'h0);
        pushEv(s + 15 + LAT, 4'h0, 4'hF, 4'h0);
        waitCycles(15);
        keyIn = 4'hF;
        drain(100);

        $display("[TB] reset during press debounce");
        @(negedge sysClk);
        keyIn[2] = 1'b0;
        waitCycles(5);
        applyReset();
        waitCycles(2);
        keyIn[2] = 1'b1;
        waitCycles(2);
        releaseReset();
        drain(50);

        $display("[TB] reset while held");
        @(negedge sysClk);
        keyIn[0] = 1'b0;
        s = edgeNo + 1;
        pushEv(s + LAT, 4'b0001, 4'h0, 4'h0);
        waitCycles(20);
        applyReset();
        waitCycles(2);
        keyIn[0] = 1'b1;
        waitCycles(2);
        releaseReset();
        drain(50);

        $display("[TB] press after reset recovery");
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
